mult_scheduler: RTL and testbench

MULT_SCHEDULER -- requirements
Module: mult_scheduler

---
 rtl/mult_sched_pkg.sv | 19 +
 rtl/mult_sign_fix.sv | 30 +++
 rtl/mult_scheduler.sv | 170 +++++++++++++++++
 tb/tb_mult_scheduler.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_sched_pkg.sv
// ---------------------------------------------------------------------------
// mult_sched_pkg
// Shared definitions for schedulers that front a shared arithmetic unit.
// Holds the scheduler state encoding and the expected multiplier latency
// so future divider schedulers can reuse the same FSM shape.
// ---------------------------------------------------------------------------
package mult_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_e;

  // Edges between the multiplier sampling mul_start and raising mul_done.
  localparam int MUL_LATENCY = 2;

endpackage

// File: rtl/mult_sign_fix.sv
// ---------------------------------------------------------------------------
// mult_sign_fix
// Sign handling around an unsigned multiplier.
//   a_in, b_in, is_signed -> a_mag, b_mag : operand magnitudes
//                         -> negate       : product must be negated
//   y_in, neg_in          -> y_out        : conditionally negated product
// Purely combinational.
// ---------------------------------------------------------------------------
module mult_sign_fix (
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic        is_signed,
  output logic [31:0] a_mag,
  output logic [31:0] b_mag,
  output logic        negate,
  input  logic [63:0] y_in,
  input  logic        neg_in,
  output logic [63:0] y_out
);

  // Two's-complement negate of 0x80000000 wraps back to 0x80000000,
  // which is exactly its unsigned magnitude.
  always_comb begin
    a_mag  = (is_signed && a_in[31]) ? (32'd0 - a_in) : a_in;
    b_mag  = (is_signed && b_in[31]) ? (32'd0 - b_in) : b_in;
    negate = is_signed && (a_in[31] ^ b_in[31]);
    y_out  = neg_in ? (64'd0 - y_in) : y_in;
  end

endmodule

// File: rtl/mult_scheduler.sv
// ---------------------------------------------------------------------------
// mult_scheduler
// Arbitrates two requesters onto one shared unsigned 32x32 multiplier and
// returns the signed/unsigned, high/low product half to a single consumer.
//   clk, reset                 : clock, async active-high reset
//   reqN_valid/ready/a/b       : request handshake and operands (N = 0,1)
//   reqN_signed, reqN_hi       : signed multiply, return upper half
//   resp_valid/ready/id/data   : response handshake, owner, result half
//   mul_a, mul_b, mul_start    : to the shared multiplier
//   mul_y, mul_done            : product and done flag from the multiplier
// One operation in flight: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// ---------------------------------------------------------------------------
module mult_scheduler
  import mult_sched_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_signed,
  input  logic        req0_hi,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_signed,
  input  logic        req1_hi,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [31:0] resp_data,
  input  logic        resp_ready,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_start,
  input  logic [63:0] mul_y,
  input  logic        mul_done
);

  sched_state_e state_q, state_d;
  logic         prio_q, prio_d;
  logic         id_q, id_d;
  logic         hi_q, hi_d;
  logic         neg_q, neg_d;
  logic [31:0]  a_mag_q, a_mag_d;
  logic [31:0]  b_mag_q, b_mag_d;
  logic         resp_valid_q, resp_valid_d;
  logic [31:0]  resp_data_q, resp_data_d;
  logic         mul_start_q, mul_start_d;

  logic         grant0, grant1;
  logic [31:0]  sel_a, sel_b;
  logic         sel_signed, sel_hi;
  logic [31:0]  fix_a_mag, fix_b_mag;
  logic         fix_negate;
  logic [63:0]  prod_fixed;

  // Round-robin grant; prio_q=1 means req1 wins a tie. Gated by reset so
  // no ready escapes while the block is held in reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == ST_IDLE && !reset) begin
      if (req0_valid && req1_valid) begin
        grant1 = prio_q;
        grant0 = !prio_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
    sel_a      = grant1 ? req1_a      : req0_a;
    sel_b      = grant1 ? req1_b      : req0_b;
    sel_signed = grant1 ? req1_signed : req0_signed;
    sel_hi     = grant1 ? req1_hi     : req0_hi;
  end

  mult_sign_fix u_sign_fix (
    .a_in      (sel_a),
    .b_in      (sel_b),
    .is_signed (sel_signed),
    .a_mag     (fix_a_mag),
    .b_mag     (fix_b_mag),
    .negate    (fix_negate),
    .y_in      (mul_y),
    .neg_in    (neg_q),
    .y_out     (prod_fixed)
  );

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    id_d         = id_q;
    hi_d         = hi_q;
    neg_d        = neg_q;
    a_mag_d      = a_mag_q;
    b_mag_d      = b_mag_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    mul_start_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant0 || grant1) begin
          state_d     = ST_ISSUE;
          // The requester not just granted wins the next tie.
          prio_d      = grant0;
          id_d        = grant1;
          hi_d        = sel_hi;
          neg_d       = fix_negate;
          a_mag_d     = fix_a_mag;
          b_mag_d     = fix_b_mag;
          mul_start_d = 1'b1;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (mul_done) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_data_d  = hi_q ? prod_fixed[63:32] : prod_fixed[31:0];
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          resp_data_d  = 32'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      prio_q       <= 1'b0;
      id_q         <= 1'b0;
      hi_q         <= 1'b0;
      neg_q        <= 1'b0;
      a_mag_q      <= 32'd0;
      b_mag_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'd0;
      mul_start_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      id_q         <= id_d;
      hi_q         <= hi_d;
      neg_q        <= neg_d;
      a_mag_q      <= a_mag_d;
      b_mag_q      <= b_mag_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      mul_start_q  <= mul_start_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign resp_valid = resp_valid_q;
  assign resp_id    = id_q;
  assign resp_data  = resp_data_q;
  assign mul_a      = a_mag_q;
  assign mul_b      = b_mag_q;
  assign mul_start  = mul_start_q;

endmodule

// File: tb/tb_mult_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mult_scheduler
// Directed bench for mult_scheduler with a behavioural 2-cycle unsigned
// multiplier. Inputs change on the falling edge; outputs sampled there too.
// ---------------------------------------------------------------------------
module tb_mult_scheduler;
  import mult_sched_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_signed = 1'b0, req0_hi = 1'b0;
  logic        req1_signed = 1'b0, req1_hi = 1'b0;
  logic        resp_valid, resp_id;
  logic [31:0] resp_data;
  logic        resp_ready = 1'b0;
  logic [31:0] mul_a, mul_b;
  logic        mul_start;
  logic [63:0] mul_y;
  logic        mul_done;

  logic [63:0] mdl_y = '0;
  int          mdl_cnt = 0;
  logic        mdl_done = 1'b0;
  logic        force_done = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mult_scheduler dut (
    .clk (clk), .reset (reset),
    .req0_valid (req0_valid), .req0_ready (req0_ready),
    .req0_a (req0_a), .req0_b (req0_b),
    .req0_signed (req0_signed), .req0_hi (req0_hi),
    .req1_valid (req1_valid), .req1_ready (req1_ready),
    .req1_a (req1_a), .req1_b (req1_b),
    .req1_signed (req1_signed), .req1_hi (req1_hi),
    .resp_valid (resp_valid), .resp_id (resp_id), .resp_data (resp_data),
    .resp_ready (resp_ready),
    .mul_a (mul_a), .mul_b (mul_b), .mul_start (mul_start),
    .mul_y (mul_y), .mul_done (mul_done)
  );

  // Multiplier model: not reset, so a pending done survives a DUT reset.
  always @(posedge clk) begin
    if (mul_start) begin
      mdl_y   <= {32'd0, mul_a} * {32'd0, mul_b};
      mdl_cnt <= MUL_LATENCY;
    end else if (mdl_cnt != 0) begin
      mdl_cnt <= mdl_cnt - 1;
    end
    mdl_done <= (mdl_cnt == 1) && !mul_start;
  end

  assign mul_y    = mdl_y;
  assign mul_done = mdl_done | force_done;

  // Runs one transaction for requester n; called just after a falling edge.
  task automatic run_op(input int n, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic h, output logic got_id,
                        output logic [31:0] got_data, output logic [31:0] got_mul_a,
                        output int edges, output bit timed_out);
    int w;
    timed_out = 1'b0;
    edges = 0;
    got_id = 1'b0;
    got_data = '0;
    got_mul_a = '0;
    if (n == 0) begin
      req0_a = a; req0_b = b; req0_signed = s; req0_hi = h; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_signed = s; req1_hi = h; req1_valid = 1'b1;
    end
    #1;
    w = 0;
    while (!((n == 0) ? req0_ready : req1_ready) && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (w >= 20) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      timed_out = 1'b1;
      return;
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    got_mul_a = mul_a;
    while (edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (resp_valid) break;
    end
    if (!resp_valid) begin
      timed_out = 1'b1;
      return;
    end
    got_id = resp_id;
    got_data = resp_data;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    n_checks++;
    if ({resp_valid, resp_id, resp_data, mul_start, req0_ready, req1_ready} !== 37'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got v=%b id=%b d=%h st=%b r0=%b r1=%b, want all 0",
               resp_valid, resp_id, resp_data, mul_start, req0_ready, req1_ready);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_unsigned();
    logic id; logic [31:0] d, ma; int e; bit to;
    run_op(0, 32'd7, 32'd6, 1'b0, 1'b0, id, d, ma, e, to);
    n_checks++;
    if (to !== 1'b0 || e != 4) begin
      n_fail++;
      $display("[TB] FAIL basic_latency: got edges=%0d timeout=%b, want 4", e, to);
    end
    n_checks++;
    if (id !== 1'b0 || d !== 32'd42) begin
      n_fail++;
      $display("[TB] FAIL basic_result: got id=%b data=%h, want id=0 data=0000002a", id, d);
    end
    n_checks++;
    if (resp_valid !== 1'b0 || resp_data !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL basic_idle_resp: got v=%b d=%h, want 0/0", resp_valid, resp_data);
    end
  endtask

  task automatic test_signed_hi();
    logic id; logic [31:0] d, ma; int e; bit to;
    run_op(1, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b1, id, d, ma, e, to);
    n_checks++;
    if (to !== 1'b0 || id !== 1'b1 || d !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("[TB] FAIL signed_hi: got id=%b data=%h to=%b, want id=1 data=ffffffff", id, d, to);
    end
    n_checks++;
    if (ma !== 32'd1) begin
      n_fail++;
      $display("[TB] FAIL signed_mag: got mul_a=%h, want 00000001", ma);
    end
    run_op(1, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b1, id, d, ma, e, to);
    n_checks++;
    if (to !== 1'b0 || id !== 1'b1 || d !== 32'h00000001) begin
      n_fail++;
      $display("[TB] FAIL unsigned_hi: got id=%b data=%h to=%b, want id=1 data=00000001", id, d, to);
    end
  endtask

  task automatic test_min_int();
    logic id; logic [31:0] d, ma; int e; bit to;
    run_op(0, 32'h80000000, 32'h80000000, 1'b1, 1'b1, id, d, ma, e, to);
    n_checks++;
    if (to !== 1'b0 || d !== 32'h40000000 || ma !== 32'h80000000) begin
      n_fail++;
      $display("[TB] FAIL minint_hi: got data=%h mul_a=%h to=%b, want 40000000/80000000", d, ma, to);
    end
    run_op(0, 32'h80000000, 32'h80000000, 1'b1, 1'b0, id, d, ma, e, to);
    n_checks++;
    if (to !== 1'b0 || d !== 32'h00000000) begin
      n_fail++;
      $display("[TB] FAIL minint_lo: got data=%h to=%b, want 00000000", d, to);
    end
  endtask

  task automatic test_round_robin();
    int grants[4];
    int k = 0;
    int cyc = 0;
    bit both_seen = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req0_a = 32'd3; req0_b = 32'd4; req0_signed = 1'b0; req0_hi = 1'b0;
    req1_a = 32'd5; req1_b = 32'd6; req1_signed = 1'b0; req1_hi = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    resp_ready = 1'b1;
    while (k < 4 && cyc < 100) begin
      #1;
      if (req0_ready && req1_ready) both_seen = 1'b1;
      if (req0_ready) begin grants[k] = 0; k++; end
      else if (req1_ready) begin grants[k] = 1; k++; end
      @(posedge clk);
      #1;
      if (k == 4) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (both_seen) begin
      n_fail++;
      $display("[TB] FAIL rr_onehot: got both readies high in one cycle, want at most one");
    end
    n_checks++;
    if (k != 4 || grants[0] != 0 || grants[1] != 1 || grants[2] != 0 || grants[3] != 1) begin
      n_fail++;
      $display("[TB] FAIL rr_order: got %0d grants %0d,%0d,%0d,%0d, want 0,1,0,1",
               k, grants[0], grants[1], grants[2], grants[3]);
    end
    repeat (10) @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic id; logic [31:0] d, ma; int e; bit to;
    int w = 0;
    bit early_ready = 1'b0;
    bit unstable = 1'b0;
    req0_a = 32'd3; req0_b = 32'd5; req0_signed = 1'b0; req0_hi = 1'b0;
    req0_valid = 1'b1;
    #1;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_a = 32'd10; req1_b = 32'd10; req1_signed = 1'b0; req1_hi = 1'b0;
    req1_valid = 1'b1;
    @(negedge clk);
    while (!resp_valid && w < 20) begin
      #1;
      if (req1_ready) early_ready = 1'b1;
      @(negedge clk);
      w++;
    end
    repeat (10) begin
      #1;
      if (req1_ready) early_ready = 1'b1;
      if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_data !== 32'd15) unstable = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (unstable || w >= 20) begin
      n_fail++;
      $display("[TB] FAIL bp_stable: got v=%b id=%b d=%h wait=%0d, want 1/0/0000000f held",
               resp_valid, resp_id, resp_data, w);
    end
    n_checks++;
    if (early_ready) begin
      n_fail++;
      $display("[TB] FAIL bp_no_ready: got req1_ready=1 before drain, want 0");
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    n_checks++;
    if (req1_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL bp_after_drain: got req1_ready=%b, want 1", req1_ready);
    end
    @(negedge clk);
    run_op(1, 32'd10, 32'd10, 1'b0, 1'b0, id, d, ma, e, to);
    n_checks++;
    if (to !== 1'b0 || id !== 1'b1 || d !== 32'd100) begin
      n_fail++;
      $display("[TB] FAIL bp_second: got id=%b data=%h to=%b, want 1/00000064", id, d, to);
    end
  endtask

  task automatic test_reset_mid_op();
    logic id; logic [31:0] d, ma; int e; bit to;
    bit saw_valid = 1'b0;
    req0_a = 32'd9; req0_b = 32'd9; req0_signed = 1'b0; req0_hi = 1'b0;
    req0_valid = 1'b1;
    #1;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (resp_valid !== 1'b0 || mul_start !== 1'b0 || resp_data !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL midreset_async: got v=%b st=%b d=%h, want 0/0/0", resp_valid, mul_start, resp_data);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) saw_valid = 1'b1;
    end
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) saw_valid = 1'b1;
    end
    n_checks++;
    if (saw_valid) begin
      n_fail++;
      $display("[TB] FAIL midreset_no_resp: got resp_valid=1 after abandon, want 0");
    end
    run_op(0, 32'd7, 32'd6, 1'b0, 1'b0, id, d, ma, e, to);
    n_checks++;
    if (to !== 1'b0 || e != 4 || id !== 1'b0 || d !== 32'd42) begin
      n_fail++;
      $display("[TB] FAIL midreset_recover: got id=%b data=%h edges=%0d to=%b, want 0/0000002a/4",
               id, d, e, to);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_unsigned();
    test_signed_hi();
    test_min_int();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case a task waits forever on something unexpected.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
